// File: rtl/ni_flit_sequencer_pkg.sv
// Shared constants for the NI flit sequencer: flit type encodings and sequencer states.
// The optional stall counter is enabled by NI_SEQ_STALL_CNT_EN.
package ni_flit_sequencer_pkg;

  localparam int unsigned FTYPE_W = 2;

  localparam logic [FTYPE_W-1:0] FTYPE_IDLE = 2'd0;
  localparam logic [FTYPE_W-1:0] FTYPE_HEAD = 2'd1;
  localparam logic [FTYPE_W-1:0] FTYPE_BODY = 2'd2;
  localparam logic [FTYPE_W-1:0] FTYPE_TAIL = 2'd3;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_HDR  = 2'd1,
    SEQ_PAY  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ni_flit_sequencer_sat_counter.sv
// Saturating event counter used for the optional stall statistic.
// Only present when NI_SEQ_STALL_CNT_EN is defined.
`ifdef NI_SEQ_STALL_CNT_EN
module ni_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/ni_flit_sequencer.sv
// Packet sequencer driving the NI flit composer selects, one flit per handshake.
// Optional stall counter output stall_cnt enabled by NI_SEQ_STALL_CNT_EN.
module ni_flit_sequencer
  import ni_flit_sequencer_pkg::*;
#(
  parameter int unsigned FTYPEWD = FTYPE_W,
  parameter int unsigned HIDX_W  = 2,
  parameter int unsigned PIDX_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [HIDX_W:0]    req_hdr_flits,
  input  logic [PIDX_W:0]    req_pay_flits,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic [FTYPEWD-1:0] flit_type,
  output logic               is_payload,
  output logic [HIDX_W-1:0]  hdr_idx,
  output logic [PIDX_W-1:0]  pay_idx,
  output logic               busy,
  output logic               err_len
`ifdef NI_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam logic [HIDX_W:0] HDR_MAX = {1'b1, {HIDX_W{1'b0}}};
  localparam logic [PIDX_W:0] PAY_MAX = {1'b1, {PIDX_W{1'b0}}};

  seq_state_t        state, state_nxt;
  logic [HIDX_W:0]   hdr_cnt, hdr_cnt_nxt;
  logic [PIDX_W:0]   pay_cnt, pay_cnt_nxt;
  logic [HIDX_W-1:0] hdr_idx_nxt;
  logic [PIDX_W-1:0] pay_idx_nxt;
  logic              err_nxt;
  logic              desc_legal;
  logic              hdr_last;
  logic              pay_last;

  // A one-flit packet cannot be both HEAD and TAIL, so it is rejected.
  assign desc_legal = (req_hdr_flits != '0) &&
                      (req_hdr_flits <= HDR_MAX) &&
                      (req_pay_flits <= PAY_MAX) &&
                      !((req_hdr_flits == (HIDX_W+1)'(1)) && (req_pay_flits == '0));

  assign hdr_last = ({1'b0, hdr_idx} == (hdr_cnt - (HIDX_W+1)'(1)));
  assign pay_last = ({1'b0, pay_idx} == (pay_cnt - (PIDX_W+1)'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      hdr_cnt <= '0;
      pay_cnt <= '0;
      hdr_idx <= '0;
      pay_idx <= '0;
      err_len <= 1'b0;
    end else begin
      state   <= state_nxt;
      hdr_cnt <= hdr_cnt_nxt;
      pay_cnt <= pay_cnt_nxt;
      hdr_idx <= hdr_idx_nxt;
      pay_idx <= pay_idx_nxt;
      err_len <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hdr_cnt_nxt = hdr_cnt;
    pay_cnt_nxt = pay_cnt;
    hdr_idx_nxt = hdr_idx;
    pay_idx_nxt = pay_idx;
    err_nxt     = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (req_valid) begin
          if (desc_legal) begin
            hdr_cnt_nxt = req_hdr_flits;
            pay_cnt_nxt = req_pay_flits;
            hdr_idx_nxt = '0;
            pay_idx_nxt = '0;
            state_nxt   = SEQ_HDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEQ_HDR: begin
        if (flit_ready) begin
          if (hdr_last) begin
            if (pay_cnt != '0) begin
              state_nxt = SEQ_PAY;
            end else begin
              state_nxt   = SEQ_IDLE;
              hdr_idx_nxt = '0;
            end
          end else begin
            hdr_idx_nxt = hdr_idx + HIDX_W'(1);
          end
        end
      end
      SEQ_PAY: begin
        if (flit_ready) begin
          if (pay_last) begin
            state_nxt   = SEQ_IDLE;
            hdr_idx_nxt = '0;
            pay_idx_nxt = '0;
          end else begin
            pay_idx_nxt = pay_idx + PIDX_W'(1);
          end
        end
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // All flit outputs decode from registered state; flit_ready never reaches them.
  always_comb begin
    req_ready  = (state == SEQ_IDLE);
    flit_valid = (state != SEQ_IDLE);
    busy       = (state != SEQ_IDLE);
    is_payload = (state == SEQ_PAY);
    flit_type  = FTYPEWD'(FTYPE_IDLE);
    unique case (state)
      SEQ_HDR: begin
        if (hdr_idx == '0) begin
          flit_type = FTYPEWD'(FTYPE_HEAD);
        end else if (hdr_last && (pay_cnt == '0)) begin
          flit_type = FTYPEWD'(FTYPE_TAIL);
        end else begin
          flit_type = FTYPEWD'(FTYPE_BODY);
        end
      end
      SEQ_PAY: begin
        flit_type = pay_last ? FTYPEWD'(FTYPE_TAIL) : FTYPEWD'(FTYPE_BODY);
      end
      default: flit_type = FTYPEWD'(FTYPE_IDLE);
    endcase
  end

`ifdef NI_SEQ_STALL_CNT_EN
  ni_sat_counter #(.W(16)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flit_valid && !flit_ready),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ni_flit_sequencer.sv
// Self-checking bench for ni_flit_sequencer against a packet-list reference model.
// Covers the stall counter when NI_SEQ_STALL_CNT_EN is defined.
module tb_ni_flit_sequencer;
  import ni_flit_sequencer_pkg::*;

  localparam int unsigned HW = 2;
  localparam int unsigned PW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [HW:0]   req_hdr_flits;
  logic [PW:0]   req_pay_flits;
  logic          flit_valid;
  logic          flit_ready;
  logic [1:0]    flit_type;
  logic          is_payload;
  logic [HW-1:0] hdr_idx;
  logic [PW-1:0] pay_idx;
  logic          busy;
  logic          err_len;
`ifdef NI_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  ni_flit_sequencer #(.FTYPEWD(2), .HIDX_W(HW), .PIDX_W(PW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_hdr_flits (req_hdr_flits),
    .req_pay_flits (req_pay_flits),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .flit_type     (flit_type),
    .is_payload    (is_payload),
    .hdr_idx       (hdr_idx),
    .pay_idx       (pay_idx),
    .busy          (busy),
    .err_len       (err_len)
`ifdef NI_SEQ_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] ftype;
    logic       pay;
    int         idx;
  } flit_t;

  int checks   = 0;
  int failures = 0;
  int total_stalls = 0;
  int cyc = 0;
  int accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int h, input int p);
    return (h >= 1) && (h <= 4) && (p <= 16) && (h + p != 1);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_flit_valid"}, 32'(flit_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ftype"}, 32'(flit_type), 32'(FTYPE_IDLE));
`ifdef NI_SEQ_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(total_stalls));
`endif
  endtask

  // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random; abort_at: flit index to reset at (-1 none)
  task automatic run_packet(input string tag, input int h, input int p, input int mode, input int abort_at);
    flit_t q[$];
    flit_t f;
    logic rdy;
    int n;
    for (int i = 0; i < h; i++) begin
      f.pay = 1'b0; f.idx = i;
      if (i == 0) f.ftype = FTYPE_HEAD;
      else if (i == h - 1 && p == 0) f.ftype = FTYPE_TAIL;
      else f.ftype = FTYPE_BODY;
      q.push_back(f);
    end
    for (int j = 0; j < p; j++) begin
      f.pay = 1'b1; f.idx = j;
      f.ftype = (j == p - 1) ? FTYPE_TAIL : FTYPE_BODY;
      q.push_back(f);
    end
    @(negedge clock);
    check_idle({tag, "_pre"});
    chk({tag, "_pre_err"}, 32'(err_len), 0);
    req_valid = 1'b1;
    req_hdr_flits = (HW+1)'(h);
    req_pay_flits = (PW+1)'(p);
    @(posedge clock);
    accepted = 0;
    for (int k = 0; k < q.size(); k++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (k == abort_at) begin
          flit_ready = 1'b0;
          req_valid = 1'b0;
          reset = 1'b1;
          #1;
          total_stalls = 0;
          check_idle({tag, "_rst"});
          chk({tag, "_rst_payload"}, 32'(is_payload), 0);
          chk({tag, "_rst_hidx"}, 32'(hdr_idx), 0);
          chk({tag, "_rst_pidx"}, 32'(pay_idx), 0);
          chk({tag, "_rst_err"}, 32'(err_len), 0);
          #1 reset = 1'b0;
          return;
        end
        chk({tag, "_valid"}, 32'(flit_valid), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_ready_lo"}, 32'(req_ready), 0);
        chk({tag, "_ftype"}, 32'(flit_type), 32'(q[k].ftype));
        chk({tag, "_is_payload"}, 32'(is_payload), 32'(q[k].pay));
        if (q[k].pay) chk({tag, "_pay_idx"}, 32'(pay_idx), 32'(q[k].idx));
        else chk({tag, "_hdr_idx"}, 32'(hdr_idx), 32'(q[k].idx));
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        if (c == 7) rdy = 1'b1;
        cyc++;
        flit_ready = rdy;
        // Garbage descriptors while busy must be ignored.
        req_valid = rdy ? 1'b0 : 1'($urandom);
        req_hdr_flits = (HW+1)'($urandom);
        req_pay_flits = (PW+1)'($urandom);
        @(posedge clock);
        if (rdy) begin
          accepted++;
          break;
        end
        total_stalls++;
      end
    end
    n = q.size();
    @(negedge clock);
    req_valid = 1'b0;
    flit_ready = 1'b0;
    chk({tag, "_accepted"}, 32'(accepted), 32'(n));
    check_idle({tag, "_post"});
  endtask

  task automatic run_illegal(input string tag, input int h, input int p);
    @(negedge clock);
    check_idle({tag, "_pre"});
    req_valid = 1'b1;
    req_hdr_flits = (HW+1)'(h);
    req_pay_flits = (PW+1)'(p);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk({tag, "_err_hi"}, 32'(err_len), 1);
    check_idle({tag, "_mid"});
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_err_lo"}, 32'(err_len), 0);
    check_idle({tag, "_post"});
  endtask

  initial begin
    int h, p;
    reset = 1'b1;
    req_valid = 1'b0;
    req_hdr_flits = '0;
    req_pay_flits = '0;
    flit_ready = 1'b0;
    #2;
    check_idle("reset");
    chk("reset_payload", 32'(is_payload), 0);
    chk("reset_hidx", 32'(hdr_idx), 0);
    chk("reset_pidx", 32'(pay_idx), 0);
    chk("reset_err", 32'(err_len), 0);
    @(negedge clock);
    reset = 1'b0;

    run_packet("h2p3", 2, 3, 0, -1);
    run_packet("h2p0", 2, 0, 0, -1);
    cyc = 0;
    run_packet("h1p4_stall", 1, 4, 1, -1);
    run_illegal("ill_h1p0", 1, 0);
    run_packet("after_ill1", 2, 1, 0, -1);
    run_illegal("ill_h0p5", 0, 5);
    run_packet("after_ill2", 1, 2, 2, -1);
    run_illegal("ill_h5", 5, 2);
    run_illegal("ill_p17", 1, 17);
    run_packet("max", 4, 16, 0, -1);
    run_packet("max_rnd", 4, 16, 2, -1);
    run_packet("abort", 2, 4, 2, 4);
    run_packet("after_abort", 3, 2, 0, -1);

    for (int r = 0; r < 30; r++) begin
      h = $urandom_range(0, 7);
      p = $urandom_range(0, 31);
      if (r % 3 != 0) begin
        h = $urandom_range(1, 4);
        p = $urandom_range(0, 16);
      end
      if (legal(h, p)) run_packet("rnd", h, p, 2, -1);
      else run_illegal("rnd_ill", h, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ni_flit_sequencer.md
# ni_flit_sequencer

Packet sequencer for the initiator NI flit composer. It accepts one packet descriptor (header flit count and payload flit count) and, one flit per handshake, drives the composer's select and type inputs: `flit_type`, `is_payload`, and the header/payload chunk indices. The flit-valid/ready handshake runs toward the NI output buffer. It sits between the NI request FSM and the flit composer, so the composer itself stays purely combinational.

## Interface
Parameters:
- `FTYPEWD`, from `noc_parameters.v`: flit type field width.
- `HIDX_W`, 2: header chunk index width. Up to 2^HIDX_W header flits.
- `PIDX_W`, 4: payload chunk index width. Up to 2^PIDX_W payload flits.

Ports:
- `clock`, input, 1: single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: packet descriptor valid.
- `req_ready`, output, 1: descriptor accepted when `req_valid && req_ready`.
- `req_hdr_flits`, input, HIDX_W+1: header flit count, 1..2^HIDX_W.
- `req_pay_flits`, input, PIDX_W+1: payload flit count, 0..2^PIDX_W.
- `flit_valid`, output, 1: composer output holds a valid flit.
- `flit_ready`, input, 1: downstream buffer accepts the flit.
- `flit_type`, output, FTYPEWD: type of the current flit.
- `is_payload`, output, 1: composer selects the payload chunk.
- `hdr_idx`, output, HIDX_W: header chunk select.
- `pay_idx`, output, PIDX_W: payload chunk select.
- `busy`, output, 1: a packet is in flight.
- `err_len`, output, 1: one-cycle pulse when an illegal descriptor is dropped.

## Operation
- FSM states: IDLE, HDR, PAY.
- **IDLE.** `req_ready`=1 and `flit_valid`=0.
  - On accept of a legal descriptor: latch both counts, clear the indices, go to HDR.
  - Illegal descriptors: `hdr`=0, `hdr` > 2^HIDX_W, `pay` > 2^PIDX_W, or total length 1.
  - On an illegal descriptor: pulse `err_len`, stay in IDLE, emit no flits.
- **HDR.** `is_payload`=0 and `hdr_idx` = current count.
  - First flit of the packet is FTYPE_HEAD.
  - Other flits are FTYPE_BODY, except the last flit of the packet, which is FTYPE_TAIL.
  - On `flit_valid && flit_ready`, `hdr_idx` increments.
  - After the last header flit: go to PAY if `pay`>0, else go to IDLE.
- **PAY.** `is_payload`=1 and `pay_idx` = current count.
  - Last payload flit is FTYPE_TAIL; all others are FTYPE_BODY.
  - After the last payload flit is accepted, go to IDLE.
- Flit type encodings `FTYPE_IDLE`, `FTYPE_HEAD`, `FTYPE_BODY`, `FTYPE_TAIL` are defined in `noc_parameters.v`. `flit_type` = FTYPE_IDLE whenever `flit_valid`=0.
- `busy` = (state != IDLE).
- Counts are compared at HIDX_W+1 / PIDX_W+1 width. Indices never wrap within a packet; index = count−1 on the last flit.

## Timing
- Reset values:
  - FSM state IDLE.
  - `req_ready`=1.
  - `flit_valid`=0, `flit_type`=FTYPE_IDLE, `is_payload`=0.
  - `hdr_idx`=0, `pay_idx`=0.
  - `busy`=0, `err_len`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `flit_ready` to `flit_valid`.
- Latency: descriptor accepted in cycle N, HEAD flit valid in cycle N+1.
- Throughput: one flit per cycle while `flit_ready`=1.
- One idle cycle between packets: `req_ready` is only high in IDLE.
- While `flit_valid`=1 and `flit_ready`=0, every output holds stable (valid/ready rule: no retraction, no change).
- `err_len` rises in cycle N+1 after the illegal accept and lasts exactly one cycle.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned and not resumed.
- Descriptor inputs are ignored outside IDLE.

## Configuration
- `NI_SEQ_STALL_CNT_EN`
  - **Defined:** adds output `stall_cnt` [15:0]. It increments every cycle with `flit_valid && !flit_ready`, saturates at 16'hFFFF, resets to 0, and is never cleared otherwise.
  - **Undefined:** the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Add to `noc_parameters.v`:
  - state encodings `SEQ_IDLE`/`SEQ_HDR`/`SEQ_PAY`;
  - the `FTYPE_*` constants, if missing.
- Single module. The optional stall counter is a small sub-module `ni_sat_counter`, instantiated under the macro.

## Test plan
- **hdr=2, pay=3, `flit_ready`=1.** Expect 5 consecutive flits: HEAD(h0), BODY(h1), BODY(p0), BODY(p1), TAIL(p2). `busy` is high for 5 cycles, then `req_ready`=1.
- **hdr=2, pay=0.** Expect HEAD(h0), TAIL(h1), `is_payload`=0 throughout, back to IDLE.
- **hdr=1, pay=4, `flit_ready` toggling 1,0,0,1…** Outputs stay stable during stalls. Exactly 5 flits are accepted, with `pay_idx` sequence 0..3. With the macro defined, `stall_cnt` equals the stall cycle count.
- **Illegal descriptors.** hdr=1, pay=0 → `err_len` pulses once, no flit emitted. hdr=0, pay=5 → same. Each is followed by a legal packet that completes normally.
- **hdr=4, pay=16 (maximum).** Indices reach 3 and 15 with no wrap; 20 flits total, final flit TAIL.
- **Reset during the third payload flit.** All outputs return to reset values within the same cycle. The next descriptor starts cleanly with HEAD(h0).
